// File: rtl/opmode_mux_pipe.sv
// Operand-select multiplexer for the post-adder datapath.
// It has optional select (S) and output (O) pipeline stages with valid/ready flow control.
module opmode_mux_pipe #(
    parameter int WIDTH     = 48,
    parameter int NUM_IN    = 3,
    parameter bit ZERO_SEL0 = 1'b1,
    parameter bit SEL_REG   = 1'b1,
    parameter bit OUT_REG   = 1'b1,
    localparam int SEL_W_RAW = $clog2(NUM_IN + int'(ZERO_SEL0)),
    localparam int SEL_W     = (SEL_W_RAW < 1) ? 1 : SEL_W_RAW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic                    flush_i,
    input  logic                    err_clr_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_err_o,
    output logic [7:0]              err_count_o
);

    localparam bit ANY_REG = SEL_REG || OUT_REG;

    // The MSB of the result is the out-of-range flag. The lower bits hold the selected slice, or zero.
    function automatic logic [WIDTH:0] decode(input logic [SEL_W-1:0] s,
                                              input logic [NUM_IN*WIDTH-1:0] d);
        logic [WIDTH:0] r;
        logic           hit;
        r   = '0;
        hit = ZERO_SEL0 && (s == '0);
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(s) == 32'(i + int'(ZERO_SEL0))) begin
                r[WIDTH-1:0] = d[i*WIDTH +: WIDTH];
                hit          = 1'b1;
            end else begin
                r = r;
            end
        end
        r[WIDTH] = ~hit;
        return r;
    endfunction

    logic                    s_valid_q, s_valid_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_IN*WIDTH-1:0] s_data_q, s_data_d;
    logic                    o_valid_q, o_valid_d;
    logic [WIDTH-1:0]        o_data_q, o_data_d;
    logic                    o_err_q, o_err_d;
    logic [7:0]              err_count_q, err_count_d;

    logic           o_ready_s, s_ready_s, up_valid_s;
    logic [WIDTH:0] up_dec_s;

    // The ready chain is combinational from the output back to the input, so no bubbles are inserted.
    assign o_ready_s  = OUT_REG ? (!o_valid_q || out_ready_i) : out_ready_i;
    assign s_ready_s  = SEL_REG ? (!s_valid_q || o_ready_s) : o_ready_s;
    assign in_ready_o = ANY_REG ? (s_ready_s && !flush_i) : out_ready_i;

    assign up_valid_s = SEL_REG ? s_valid_q
                                : (ANY_REG ? (in_valid_i && !flush_i) : in_valid_i);
    assign up_dec_s   = SEL_REG ? decode(sel_q, s_data_q) : decode(sel_i, in_data_i);

    assign out_valid_o = OUT_REG ? o_valid_q : up_valid_s;
    assign out_data_o  = OUT_REG ? o_data_q  : up_dec_s[WIDTH-1:0];
    assign out_err_o   = OUT_REG ? o_err_q   : up_dec_s[WIDTH];
    assign err_count_o = err_count_q;

    // Select stage next state: capture sel and the raw inputs on an accepted beat.
    always_comb begin
        s_valid_d = s_valid_q;
        sel_d     = sel_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            s_valid_d = 1'b0;
        end else if (s_ready_s) begin
            s_valid_d = in_valid_i;
            if (in_valid_i) begin
                sel_d    = sel_i;
                s_data_d = in_data_i;
            end else begin
                sel_d = sel_q;
            end
        end else begin
            s_valid_d = s_valid_q;
        end
    end

    // Output stage next state: capture the decoded operand and its error flag.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_err_d   = o_err_q;
        if (flush_i) begin
            o_valid_d = 1'b0;
        end else if (o_ready_s) begin
            o_valid_d = up_valid_s;
            if (up_valid_s) begin
                o_data_d = up_dec_s[WIDTH-1:0];
                o_err_d  = up_dec_s[WIDTH];
            end else begin
                o_err_d = o_err_q;
            end
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Error counter next state: it saturates at 255, and a clear wins over an increment.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr_i) begin
            err_count_d = 8'd0;
        end else if (out_valid_o && out_ready_i && out_err_o && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State registers. Reset clears all valid bits, the stage contents and the error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q   <= 1'b0;
            sel_q       <= '0;
            s_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_err_q     <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            s_valid_q   <= s_valid_d;
            sel_q       <= sel_d;
            s_data_q    <= s_data_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_err_q     <= o_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_opmode_mux_pipe.sv
// Directed bench for opmode_mux_pipe: a pipelined 5-input instance plus a combinational 3-input instance.
module tb_opmode_mux_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pipelined instance: WIDTH=48, NUM_IN=5, ZERO_SEL0=1, both stages enabled.
    logic         in_valid = 1'b0, in_ready, flush = 1'b0, err_clr = 1'b0;
    logic         out_valid, out_ready = 1'b1, out_err;
    logic [2:0]   sel = 3'd0;
    logic [239:0] in_data = '0;
    logic [47:0]  out_data;
    logic [7:0]   err_count;

    opmode_mux_pipe #(.WIDTH(48), .NUM_IN(5), .ZERO_SEL0(1'b1), .SEL_REG(1'b1), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sel_i(sel), .in_data_i(in_data), .flush_i(flush), .err_clr_i(err_clr),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_err_o(out_err), .err_count_o(err_count)
    );

    // Combinational instance: NUM_IN=3, ZERO_SEL0=0, no stages.
    logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_out_err;
    logic [1:0]   c_sel = 2'd0;
    logic [143:0] c_in_data = '0;
    logic [47:0]  c_out_data;
    logic [7:0]   c_err_count;

    opmode_mux_pipe #(.WIDTH(48), .NUM_IN(3), .ZERO_SEL0(1'b0), .SEL_REG(1'b0), .OUT_REG(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
        .sel_i(c_sel), .in_data_i(c_in_data), .flush_i(1'b0), .err_clr_i(1'b0),
        .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
        .out_err_o(c_out_err), .err_count_o(c_err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 48'h0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [47:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                in_valid = 1'b1;
                sel = 3'(i);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                exp = (i == 1) ? 48'h0 : 48'h1000 + 48'(i - 2);
                checks++; if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_beat%0d got v=%0b d=%0h e=%0b exp v=1 d=%0h e=0", i - 1, out_valid, out_data, out_err, exp);
                end
            end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_errors();
        in_valid = 1'b1; sel = 3'd6; step();
        sel = 3'd7; step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 48'h0) begin
            failures++; $display("FAIL err_beat6 got v=%0b e=%0b d=%0h exp v=1 e=1 d=0", out_valid, out_err, out_data);
        end
        step();
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 48'h0) begin
            failures++; $display("FAIL err_beat7 got v=%0b e=%0b d=%0h exp v=1 e=1 d=0", out_valid, out_err, out_data);
        end
        step();
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL err_count2 got=%0d exp=2", err_count); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL err_clr got=%0d exp=0", err_count); end
        in_valid = 1'b1; sel = 3'd7;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'd1; step();
        sel = 3'd2; step();
        sel = 3'd3;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 48'h1000) begin
                failures++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b d=%0h exp rdy=0 v=1 d=1000", i, in_ready, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 48'h1001) begin
            failures++; $display("FAIL bp_beat2 got v=%0b d=%0h exp v=1 d=1001", out_valid, out_data);
        end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 48'h1002) begin
            failures++; $display("FAIL bp_beat3 got v=%0b d=%0h exp v=1 d=1002", out_valid, out_data);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'd1; step();
        sel = 3'd2; step();
        flush = 1'b1; sel = 3'd3;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%0b exp=0", out_valid); end
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL flush_err_count got=%0d exp=255", err_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 3'd2; step();
        sel = 3'd5; step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 48'h0 || out_err !== 1'b0 || err_count !== 8'd0) begin
            failures++; $display("FAIL rstmid_async got v=%0b d=%0h e=%0b c=%0d exp 0 0 0 0", out_valid, out_data, out_err, err_count);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; sel = 3'd4; step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 48'h1003) begin
            failures++; $display("FAIL rstmid_beat got v=%0b d=%0h exp v=1 d=1003", out_valid, out_data);
        end
    endtask

    task automatic test_comb();
        c_in_valid = 1'b1; c_out_ready = 1'b1; c_sel = 2'd3;
        #1;
        checks++; if (c_out_valid !== 1'b1 || c_out_data !== 48'h0 || c_out_err !== 1'b1) begin
            failures++; $display("FAIL comb_sel3 got v=%0b d=%0h e=%0b exp v=1 d=0 e=1", c_out_valid, c_out_data, c_out_err);
        end
        c_sel = 2'd0;
        #1;
        checks++; if (c_out_data !== 48'hA0 || c_out_err !== 1'b0) begin
            failures++; $display("FAIL comb_sel0 got d=%0h e=%0b exp d=a0 e=0", c_out_data, c_out_err);
        end
        c_sel = 2'd2;
        #1;
        checks++; if (c_out_data !== 48'hA2 || c_out_err !== 1'b0) begin
            failures++; $display("FAIL comb_sel2 got d=%0h e=%0b exp d=a2 e=0", c_out_data, c_out_err);
        end
        checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL comb_ready_hi got=%0b exp=1", c_in_ready); end
        c_out_ready = 1'b0;
        #1;
        checks++; if (c_in_ready !== 1'b0) begin failures++; $display("FAIL comb_ready_lo got=%0b exp=0", c_in_ready); end
        c_in_valid = 1'b0;
        #1;
        checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL comb_valid_lo got=%0b exp=0", c_out_valid); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) in_data[i*48 +: 48] = 48'h1000 + 48'(i);
        for (int i = 0; i < 3; i++) c_in_data[i*48 +: 48] = 48'hA0 + 48'(i);
        test_reset();
        test_stream();
        test_errors();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_comb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
